// File: rtl/vdcm_ssm_pkg.sv
// Shared types and helpers for the SSM word dispatcher.
//   state_t     : dispatcher FSM states
//   ch_idx_w    : bit width of a channel index
//   q_idx_w     : bit width of a request-queue pointer
//   popcount    : number of set bits in a pop vector
//   prefix_cnt  : number of set bits below position k (slot offset for multi-push)
package vdcm_ssm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int unsigned MAX_SSM = 8;
  localparam int unsigned CNT_W   = 4;

  function automatic int unsigned ch_idx_w(input int unsigned n_ssm);
    return (n_ssm > 1) ? $clog2(n_ssm) : 1;
  endfunction

  function automatic int unsigned q_idx_w(input int unsigned n_ssm, input int unsigned depth);
    return (n_ssm * depth > 1) ? $clog2(n_ssm * depth) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_SSM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_SSM; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] prefix_cnt(input logic [MAX_SSM-1:0] v, input int unsigned k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_SSM; i++) begin
      if (i < k) begin
        c = c + CNT_W'(v[i]);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ssm_word_fifo.sv
// Per-channel word FIFO: single push, single pop, head-of-queue visible.
//   i_clk, i_rstn : clock, async active-low reset
//   i_clr         : synchronous clear (pointers and count)
//   i_push, i_din : write one word at the tail
//   i_pop         : drop the head word (caller guarantees non-empty)
//   o_head        : current head word
//   o_count       : occupancy 0..DEPTH
//   o_empty       : occupancy is zero
import vdcm_ssm_pkg::*;

module ssm_word_fifo #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;

  // Push into a full FIFO with a simultaneous pop writes the slot being
  // vacated, so head/tail stay consistent at occupancy DEPTH.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mem <= '{default: '0};
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn || i_clr)
    !(i_push && !i_pop && r_cnt == (AW+1)'(DEPTH)));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rstn || i_clr)
    !(i_pop && r_cnt == '0));

endmodule

// File: rtl/ssm_word_dispatcher.sv
// Demand-driven dispatcher of a shared coded-word stream to N_SSM substream FIFOs.
//   clk, rstn        : clock, async active-low reset
//   start, flush     : begin prefill (IDLE only) / synchronous clear to IDLE
//   in_valid/in_ready/in_data : upstream word handshake
//   ssm_rd_en        : per-channel pop strobes
//   ssm_data         : per-channel head words, channel k at [k*W +: W]
//   ssm_valid        : per-channel non-empty
//   busy             : FSM not in IDLE
//   err_underflow    : sticky, pop attempted on an empty channel
import vdcm_ssm_pkg::*;

module ssm_word_dispatcher #(
  parameter int unsigned N_SSM = 4,
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [N_SSM-1:0]   ssm_rd_en,
  output logic [N_SSM*W-1:0] ssm_data,
  output logic [N_SSM-1:0]   ssm_valid,
  output logic               busy,
  output logic               err_underflow
);

  localparam int unsigned QD = N_SSM * DEPTH;
  localparam int unsigned QW = q_idx_w(N_SSM, DEPTH);
  localparam int unsigned CW = ch_idx_w(N_SSM);
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  state_t        r_state;
  logic [QW-1:0] r_pf_cnt;
  logic [CW-1:0] r_pf_ch;
  logic [CW-1:0] r_q [QD];
  logic [QW-1:0] r_q_wr;
  logic [QW-1:0] r_q_rd;
  logic [QW:0]   r_q_cnt;
  logic          r_err;
  logic          r_in_ready;
  logic          r_busy;

  logic [W-1:0]       w_head  [N_SSM];
  logic [OW-1:0]      w_count [N_SSM];
  logic [N_SSM-1:0]   w_empty;
  logic [N_SSM-1:0]   w_pop;
  logic [N_SSM-1:0]   w_udf;
  logic [N_SSM-1:0]   w_req;
  logic [N_SSM-1:0]   w_push;
  logic [MAX_SSM-1:0] w_req_ext;
  logic [CNT_W-1:0]   w_npush;
  logic [QW-1:0]      w_slot [N_SSM];
  logic               w_acc;
  logic               w_deq;
  logic [CW-1:0]      w_dst_ch;
  logic [QW:0]        w_q_cnt_nxt;

  // Queue pointers wrap modulo QD, which need not be a power of two.
  function automatic logic [QW-1:0] q_wrap(input logic [QW-1:0] base, input logic [CNT_W-1:0] off);
    logic [QW:0] s;
    s = {1'b0, base} + (QW+1)'(off);
    if (s >= (QW+1)'(QD)) begin
      s = s - (QW+1)'(QD);
    end
    return s[QW-1:0];
  endfunction

  assign w_pop     = ssm_rd_en & ~w_empty & {N_SSM{~flush}};
  assign w_udf     = ssm_rd_en & w_empty;
  assign w_req     = (r_state == ST_RUN) ? w_pop : '0;
  assign w_req_ext = MAX_SSM'(w_req);
  assign w_npush   = popcount(w_req_ext);
  assign w_acc     = in_valid & r_in_ready & ~flush;
  assign w_deq     = w_acc & (r_state == ST_RUN);
  assign w_dst_ch  = (r_state == ST_PREFILL) ? r_pf_ch : r_q[r_q_rd];
  assign w_q_cnt_nxt = r_q_cnt + (QW+1)'(w_npush) - (QW+1)'(w_deq);

  always_comb begin
    w_push = '0;
    for (int unsigned k = 0; k < N_SSM; k++) begin
      w_push[k] = w_acc && (w_dst_ch == CW'(k));
    end
  end

  // Simultaneous requests land in consecutive slots in ascending channel order.
  always_comb begin
    for (int unsigned k = 0; k < N_SSM; k++) begin
      w_slot[k] = q_wrap(r_q_wr, prefix_cnt(w_req_ext, k));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_pf_cnt   <= '0;
      r_pf_ch    <= '0;
      r_q        <= '{default: '0};
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_q_cnt    <= '0;
      r_err      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_q_cnt    <= '0;
      r_err      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (|w_udf) begin
        r_err <= 1'b1;
      end
      for (int unsigned k = 0; k < N_SSM; k++) begin
        if (w_req[k]) begin
          r_q[w_slot[k]] <= CW'(k);
        end
      end
      r_q_wr <= q_wrap(r_q_wr, w_npush);
      if (w_deq) begin
        r_q_rd <= q_wrap(r_q_rd, CNT_W'(1));
      end
      r_q_cnt <= w_q_cnt_nxt;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_PREFILL;
            r_pf_cnt   <= '0;
            r_pf_ch    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_PREFILL: begin
          if (w_acc) begin
            if (r_pf_cnt == QW'(QD - 1)) begin
              // Pops during prefill queue nothing, so the queue is empty here.
              r_state    <= ST_RUN;
              r_in_ready <= 1'b0;
            end else begin
              r_pf_cnt <= r_pf_cnt + QW'(1);
              r_pf_ch  <= (r_pf_ch == CW'(N_SSM - 1)) ? '0 : r_pf_ch + CW'(1);
            end
          end
        end
        ST_RUN: begin
          r_in_ready <= (w_q_cnt_nxt != '0);
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign err_underflow = r_err;

  for (genvar k = 0; k < N_SSM; k++) begin : g_ch
    ssm_word_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_clr   (flush),
      .i_push  (w_push[k]),
      .i_din   (in_data),
      .i_pop   (w_pop[k]),
      .o_head  (w_head[k]),
      .o_count (w_count[k]),
      .o_empty (w_empty[k])
    );

    assign ssm_data[k*W +: W] = w_head[k];
    assign ssm_valid[k]       = ~w_empty[k];

    a_route_fits: assert property (@(posedge clk) disable iff (!rstn || flush)
      w_push[k] |-> (w_count[k] < OW'(DEPTH) || w_pop[k]));
  end

  a_queue_cap: assert property (@(posedge clk) disable iff (!rstn || flush)
    ({1'b0, r_q_cnt} + (QW+2)'(w_npush)) <= (QW+2)'(QD));

endmodule
